// File: rtl/strtup_seq_ctrl.sv
// Wake-up sequencer: after configuration load, releases DONE, GOE, GWE and GSRN
// in a programmable phase order, optionally gated by PLL lock and the DONE pin.
module strtup_seq_ctrl #(
  parameter int DONE_PHASE   = 1,
  parameter int GOE_PHASE    = 2,
  parameter int GWE_PHASE    = 3,
  parameter int GSR_PHASE    = 3,
  parameter int PHASE_LEN    = 1,
  parameter int WAIT_LOCK    = 0,
  parameter int LOCK_TIMEOUT = 1023,
  parameter int SYNC_TO_DONE = 0
) (
  input  logic       UCLK,
  input  logic       RSTN,
  input  logic       CFG_DONE,
  input  logic       PLL_LOCK,
  input  logic       DONE_IN,
  input  logic       RESTART,
  output logic       DONE_OUT,
  output logic       GOE,
  output logic       GWE,
  output logic       GSRN,
  output logic       BUSY,
  output logic       ERR,
  output logic [2:0] PHASE
);

  if (DONE_PHASE < 1 || DONE_PHASE > 7 || GOE_PHASE < 1 || GOE_PHASE > 7 ||
      GWE_PHASE < 1 || GWE_PHASE > 7 || GSR_PHASE < 1 || GSR_PHASE > 7 ||
      PHASE_LEN < 1 || PHASE_LEN > 16 || LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 1023) begin : g_badParam
    $error("strtup_seq_ctrl: phase, PHASE_LEN or LOCK_TIMEOUT parameter out of range");
  end

  localparam logic [2:0] DonePh    = 3'(DONE_PHASE);
  localparam logic [2:0] GoePh     = 3'(GOE_PHASE);
  localparam logic [2:0] GwePh     = 3'(GWE_PHASE);
  localparam logic [2:0] GsrPh     = 3'(GSR_PHASE);
  localparam logic [3:0] DwellLast = 4'(PHASE_LEN - 1);
  localparam logic [9:0] LockLast  = 10'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCK_WAIT,
    S_SEQ,
    S_DONE,
    S_ERROR
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [3:0] dwell_q, dwell_d;
  logic [9:0] lockCnt_q, lockCnt_d;
  logic       doneIn_q, doneIn_d;
  logic       doneOut_q, doneOut_d;
  logic       goe_q, goe_d;
  logic       gwe_q, gwe_d;
  logic       gsrn_q, gsrn_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  always_ff @(posedge UCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      phase_q   <= 3'd0;
      dwell_q   <= 4'd0;
      lockCnt_q <= 10'd0;
      doneIn_q  <= 1'b0;
      doneOut_q <= 1'b0;
      goe_q     <= 1'b0;
      gwe_q     <= 1'b0;
      gsrn_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      dwell_q   <= dwell_d;
      lockCnt_q <= lockCnt_d;
      doneIn_q  <= doneIn_d;
      doneOut_q <= doneOut_d;
      goe_q     <= goe_d;
      gwe_q     <= gwe_d;
      gsrn_q    <= gsrn_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // DONE_IN is registered once so a DONE-pin stall releases on the edge after it is seen high.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    dwell_d   = dwell_q;
    lockCnt_d = lockCnt_q;
    doneIn_d  = DONE_IN;
    if (RESTART) begin
      state_d   = S_IDLE;
      phase_d   = 3'd0;
      dwell_d   = 4'd0;
      lockCnt_d = 10'd0;
      doneIn_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (CFG_DONE) begin
            if (WAIT_LOCK != 0) begin
              state_d   = S_LOCK_WAIT;
              lockCnt_d = 10'd0;
            end else begin
              state_d = S_SEQ;
              phase_d = 3'd1;
              dwell_d = 4'd0;
            end
          end
        end
        S_LOCK_WAIT: begin
          if (PLL_LOCK) begin
            state_d   = S_SEQ;
            phase_d   = 3'd1;
            dwell_d   = 4'd0;
            lockCnt_d = 10'd0;
          end else begin
            lockCnt_d = lockCnt_q + 10'd1;
            if (lockCnt_q == LockLast) state_d = S_ERROR;
          end
        end
        S_SEQ: begin
          if (dwell_q != DwellLast) begin
            dwell_d = dwell_q + 4'd1;
          end else if (SYNC_TO_DONE != 0 && phase_q == DonePh && !doneIn_q) begin
            dwell_d = dwell_q;
          end else if (phase_q == 3'd7) begin
            state_d = S_DONE;
            phase_d = 3'd0;
            dwell_d = 4'd0;
          end else begin
            phase_d = phase_q + 3'd1;
            dwell_d = 4'd0;
          end
        end
        S_DONE:  state_d = S_DONE;
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Phases only climb, so "phase reached" makes each control sticky for the rest of the run.
  always_comb begin
    doneOut_d = 1'b0;
    goe_d     = 1'b0;
    gwe_d     = 1'b0;
    gsrn_d    = 1'b0;
    busy_d    = (state_d == S_LOCK_WAIT) || (state_d == S_SEQ);
    err_d     = (state_d == S_ERROR);
    if (state_d == S_DONE) begin
      doneOut_d = 1'b1;
      goe_d     = 1'b1;
      gwe_d     = 1'b1;
      gsrn_d    = 1'b1;
    end else if (state_d == S_SEQ) begin
      doneOut_d = (phase_d >= DonePh);
      goe_d     = (phase_d >= GoePh);
      gwe_d     = (phase_d >= GwePh);
      gsrn_d    = (phase_d >= GsrPh);
    end
  end

  assign DONE_OUT = doneOut_q;
  assign GOE      = goe_q;
  assign GWE      = gwe_q;
  assign GSRN     = gsrn_q;
  assign BUSY     = busy_q;
  assign ERR      = err_q;
  assign PHASE    = phase_q;

endmodule

// File: tb/tb_strtup_seq_ctrl.sv
// Directed bench for strtup_seq_ctrl: four instances cover default ordering, long
// phases, PLL lock wait / timeout and DONE-pin synchronisation.
module tb_strtup_seq_ctrl;

  logic       UCLK;
  logic       RSTN;
  logic [3:0] cfgDone, pllLock, doneIn, restart;
  logic [3:0] doneOut, goe, gwe, gsrn, busy, err;
  logic [2:0] phase [4];

  int vectors = 0;
  int miscompares = 0;

  initial UCLK = 1'b0;
  always #5 UCLK = ~UCLK;

  strtup_seq_ctrl u_dut0 (
    .UCLK(UCLK), .RSTN(RSTN), .CFG_DONE(cfgDone[0]), .PLL_LOCK(pllLock[0]),
    .DONE_IN(doneIn[0]), .RESTART(restart[0]), .DONE_OUT(doneOut[0]), .GOE(goe[0]),
    .GWE(gwe[0]), .GSRN(gsrn[0]), .BUSY(busy[0]), .ERR(err[0]), .PHASE(phase[0]));

  strtup_seq_ctrl #(.PHASE_LEN(4), .GSR_PHASE(1), .GOE_PHASE(5)) u_dut1 (
    .UCLK(UCLK), .RSTN(RSTN), .CFG_DONE(cfgDone[1]), .PLL_LOCK(pllLock[1]),
    .DONE_IN(doneIn[1]), .RESTART(restart[1]), .DONE_OUT(doneOut[1]), .GOE(goe[1]),
    .GWE(gwe[1]), .GSRN(gsrn[1]), .BUSY(busy[1]), .ERR(err[1]), .PHASE(phase[1]));

  strtup_seq_ctrl #(.WAIT_LOCK(1), .LOCK_TIMEOUT(20)) u_dut2 (
    .UCLK(UCLK), .RSTN(RSTN), .CFG_DONE(cfgDone[2]), .PLL_LOCK(pllLock[2]),
    .DONE_IN(doneIn[2]), .RESTART(restart[2]), .DONE_OUT(doneOut[2]), .GOE(goe[2]),
    .GWE(gwe[2]), .GSRN(gsrn[2]), .BUSY(busy[2]), .ERR(err[2]), .PHASE(phase[2]));

  strtup_seq_ctrl #(.SYNC_TO_DONE(1)) u_dut3 (
    .UCLK(UCLK), .RSTN(RSTN), .CFG_DONE(cfgDone[3]), .PLL_LOCK(pllLock[3]),
    .DONE_IN(doneIn[3]), .RESTART(restart[3]), .DONE_OUT(doneOut[3]), .GOE(goe[3]),
    .GWE(gwe[3]), .GSRN(gsrn[3]), .BUSY(busy[3]), .ERR(err[3]), .PHASE(phase[3]));

  // Output bundle: {DONE_OUT, GOE, GWE, GSRN, BUSY, ERR, PHASE[2:0]}
  function automatic logic [8:0] snap(input int i);
    return {doneOut[i], goe[i], gwe[i], gsrn[i], busy[i], err[i], phase[i]};
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge UCLK);
      @(negedge UCLK);
    end
  endtask

  task automatic doReset();
    RSTN    = 1'b0;
    cfgDone = 4'b0;
    pllLock = 4'b0;
    doneIn  = 4'b0;
    restart = 4'b0;
    @(negedge UCLK);
    @(negedge UCLK);
    RSTN = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    doReset();
    for (int i = 0; i < 4; i++) begin
      got = snap(i);
      vectors++;
      if (got !== 9'b0000_00_000) begin
        miscompares++;
        $display("[TB] FAIL reset_dut%0d: got %b expected %b", i, got, 9'b0000_00_000);
      end
    end
  endtask

  task automatic test_default_order();
    logic [8:0] got;
    doReset();
    cfgDone[0] = 1'b1;
    tick(1);
    got = snap(0); vectors++;
    if (got !== 9'b1000_10_001) begin miscompares++; $display("[TB] FAIL def_edge1: got %b expected %b", got, 9'b1000_10_001); end
    tick(1);
    got = snap(0); vectors++;
    if (got !== 9'b1100_10_010) begin miscompares++; $display("[TB] FAIL def_edge2: got %b expected %b", got, 9'b1100_10_010); end
    cfgDone[0] = 1'b0;
    tick(1);
    got = snap(0); vectors++;
    if (got !== 9'b1111_10_011) begin miscompares++; $display("[TB] FAIL def_edge3: got %b expected %b", got, 9'b1111_10_011); end
    tick(4);
    got = snap(0); vectors++;
    if (got !== 9'b1111_10_111) begin miscompares++; $display("[TB] FAIL def_edge7: got %b expected %b", got, 9'b1111_10_111); end
    tick(1);
    got = snap(0); vectors++;
    if (got !== 9'b1111_00_000) begin miscompares++; $display("[TB] FAIL def_edge8_done: got %b expected %b", got, 9'b1111_00_000); end
    tick(3);
    got = snap(0); vectors++;
    if (got !== 9'b1111_00_000) begin miscompares++; $display("[TB] FAIL def_done_hold: got %b expected %b", got, 9'b1111_00_000); end
  endtask

  task automatic test_long_phase();
    logic [8:0] got;
    doReset();
    cfgDone[1] = 1'b1;
    tick(1);
    got = snap(1); vectors++;
    if (got !== 9'b1001_10_001) begin miscompares++; $display("[TB] FAIL long_edge1: got %b expected %b", got, 9'b1001_10_001); end
    tick(15);
    got = snap(1); vectors++;
    if (got !== 9'b1011_10_100) begin miscompares++; $display("[TB] FAIL long_edge16: got %b expected %b", got, 9'b1011_10_100); end
    tick(1);
    got = snap(1); vectors++;
    if (got !== 9'b1111_10_101) begin miscompares++; $display("[TB] FAIL long_edge17: got %b expected %b", got, 9'b1111_10_101); end
    tick(11);
    got = snap(1); vectors++;
    if (got !== 9'b1111_10_111) begin miscompares++; $display("[TB] FAIL long_edge28: got %b expected %b", got, 9'b1111_10_111); end
    tick(1);
    got = snap(1); vectors++;
    if (got !== 9'b1111_00_000) begin miscompares++; $display("[TB] FAIL long_edge29_done: got %b expected %b", got, 9'b1111_00_000); end
  endtask

  task automatic test_lock_wait();
    logic [8:0] got;
    // Lock arrives after 10 waiting cycles.
    doReset();
    cfgDone[2] = 1'b1;
    tick(1);
    got = snap(2); vectors++;
    if (got !== 9'b0000_10_000) begin miscompares++; $display("[TB] FAIL lock_enter: got %b expected %b", got, 9'b0000_10_000); end
    tick(10);
    got = snap(2); vectors++;
    if (got !== 9'b0000_10_000) begin miscompares++; $display("[TB] FAIL lock_waiting: got %b expected %b", got, 9'b0000_10_000); end
    pllLock[2] = 1'b1;
    tick(1);
    got = snap(2); vectors++;
    if (got !== 9'b1000_10_001) begin miscompares++; $display("[TB] FAIL lock_seen: got %b expected %b", got, 9'b1000_10_001); end
    // No lock: 20 cycles in LOCK_WAIT then ERROR.
    doReset();
    cfgDone[2] = 1'b1;
    tick(1);
    tick(19);
    got = snap(2); vectors++;
    if (got !== 9'b0000_10_000) begin miscompares++; $display("[TB] FAIL timeout_edge19: got %b expected %b", got, 9'b0000_10_000); end
    tick(1);
    got = snap(2); vectors++;
    if (got !== 9'b0000_01_000) begin miscompares++; $display("[TB] FAIL timeout_err: got %b expected %b", got, 9'b0000_01_000); end
    pllLock[2] = 1'b1;
    tick(2);
    got = snap(2); vectors++;
    if (got !== 9'b0000_01_000) begin miscompares++; $display("[TB] FAIL err_sticky: got %b expected %b", got, 9'b0000_01_000); end
    pllLock[2] = 1'b0;
    cfgDone[2] = 1'b0;
    restart[2] = 1'b1;
    tick(1);
    restart[2] = 1'b0;
    got = snap(2); vectors++;
    if (got !== 9'b0000_00_000) begin miscompares++; $display("[TB] FAIL err_restart: got %b expected %b", got, 9'b0000_00_000); end
    // Lock on the very cycle the timeout would fire: lock wins.
    doReset();
    cfgDone[2] = 1'b1;
    tick(20);
    pllLock[2] = 1'b1;
    tick(1);
    got = snap(2); vectors++;
    if (got !== 9'b1000_10_001) begin miscompares++; $display("[TB] FAIL lock_vs_timeout: got %b expected %b", got, 9'b1000_10_001); end
  endtask

  task automatic test_sync_to_done();
    logic [8:0] got;
    doReset();
    cfgDone[3] = 1'b1;
    tick(1);
    got = snap(3); vectors++;
    if (got !== 9'b1000_10_001) begin miscompares++; $display("[TB] FAIL sync_edge1: got %b expected %b", got, 9'b1000_10_001); end
    tick(12);
    got = snap(3); vectors++;
    if (got !== 9'b1000_10_001) begin miscompares++; $display("[TB] FAIL sync_frozen: got %b expected %b", got, 9'b1000_10_001); end
    doneIn[3] = 1'b1;
    tick(1);
    got = snap(3); vectors++;
    if (got !== 9'b1000_10_001) begin miscompares++; $display("[TB] FAIL sync_sample_edge: got %b expected %b", got, 9'b1000_10_001); end
    tick(1);
    got = snap(3); vectors++;
    if (got !== 9'b1100_10_010) begin miscompares++; $display("[TB] FAIL sync_release: got %b expected %b", got, 9'b1100_10_010); end
  endtask

  task automatic test_restart();
    logic [8:0] got;
    doReset();
    cfgDone[0] = 1'b1;
    tick(4);
    got = snap(0); vectors++;
    if (got !== 9'b1111_10_100) begin miscompares++; $display("[TB] FAIL rst_pre_ph4: got %b expected %b", got, 9'b1111_10_100); end
    restart[0] = 1'b1;
    tick(1);
    restart[0] = 1'b0;
    got = snap(0); vectors++;
    if (got !== 9'b0000_00_000) begin miscompares++; $display("[TB] FAIL restart_idle: got %b expected %b", got, 9'b0000_00_000); end
    tick(1);
    got = snap(0); vectors++;
    if (got !== 9'b1000_10_001) begin miscompares++; $display("[TB] FAIL restart_rerun: got %b expected %b", got, 9'b1000_10_001); end
  endtask

  task automatic test_async_reset();
    logic [8:0] got;
    doReset();
    cfgDone[0] = 1'b1;
    tick(5);
    got = snap(0); vectors++;
    if (got !== 9'b1111_10_101) begin miscompares++; $display("[TB] FAIL arst_pre_ph5: got %b expected %b", got, 9'b1111_10_101); end
    #2;
    RSTN = 1'b0;
    #1;
    got = snap(0); vectors++;
    if (got !== 9'b0000_00_000) begin miscompares++; $display("[TB] FAIL arst_immediate: got %b expected %b", got, 9'b0000_00_000); end
    @(negedge UCLK);
    got = snap(0); vectors++;
    if (got !== 9'b0000_00_000) begin miscompares++; $display("[TB] FAIL arst_held: got %b expected %b", got, 9'b0000_00_000); end
    cfgDone[0] = 1'b0;
    RSTN = 1'b1;
    tick(1);
    got = snap(0); vectors++;
    if (got !== 9'b0000_00_000) begin miscompares++; $display("[TB] FAIL arst_no_resume: got %b expected %b", got, 9'b0000_00_000); end
    cfgDone[0] = 1'b1;
    tick(1);
    got = snap(0); vectors++;
    if (got !== 9'b1000_10_001) begin miscompares++; $display("[TB] FAIL arst_resume: got %b expected %b", got, 9'b1000_10_001); end
  endtask

  initial begin
    RSTN    = 1'b0;
    cfgDone = 4'b0;
    pllLock = 4'b0;
    doneIn  = 4'b0;
    restart = 4'b0;
    test_reset();
    test_default_order();
    test_long_phase();
    test_lock_wait();
    test_sync_to_done();
    test_restart();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
